// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams a word-count header and big-endian words into IMEM, then releases the core
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             load_req,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_nrst,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, RUN, ERR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hdr_q, hdr_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [23:0]      word_q, word_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             core_nrst_q, core_nrst_d;
    logic             fire;
    logic [CNT_W-1:0] n_full;
    logic [CNT_W-1:0] words_inc;

    assign fire      = in_valid && in_ready;
    assign n_full    = {hdr_q[CNT_W-1:8], in_data};
    assign words_inc = words_q + CNT_W'(1);

    // State and datapath registers; reset parks the core in reset awaiting a header
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= HDR_HI;
            hdr_q       <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_nrst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_nrst_q <= core_nrst_d;
        end
    end

    // Next state: header evaluation, last-byte detection and restart from RUN/ERR
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI:   if (fire) state_d = HDR_LO;
            HDR_LO:   if (fire) state_d = (n_full == '0) ? RUN : (n_full > CNT_W'(DEPTH)) ? ERR : DATA;
            DATA:     if (fire && cnt_q == 2'd3 && words_inc == hdr_q) state_d = RUN;
            RUN, ERR: if (load_req) state_d = HDR_HI;
            default:  state_d = HDR_HI;
        endcase
    end

    // Datapath: header capture, MSB-first word assembly and the one-cycle write strobe
    always_comb begin
        hdr_d       = hdr_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        core_nrst_d = (state_q == RUN) && !load_req;
        if (fire && state_q == HDR_HI) hdr_d[CNT_W-1:8] = in_data;
        if (fire && state_q == HDR_LO) begin
            hdr_d[7:0] = in_data;
            if (state_d == DATA) begin
                words_d = '0;
                cnt_d   = '0;
            end
        end
        if (fire && state_q == DATA) begin
            word_d = {word_q[15:0], in_data};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                we_d    = 1'b1;
                wdata_d = {word_q, in_data};
                addr_d  = {{(30-CNT_W){1'b0}}, words_q, 2'b00};
                words_d = words_inc;
            end
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
        busy     = in_ready;
        error    = (state_q == ERR);
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_nrst    = core_nrst_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus hand-written gap and abort sequences for imem_loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        load_req = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_nrst;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    int compared = 0;
    int mismatched = 0;

    imem_loader #(.DEPTH(256), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_nrst(core_nrst), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  d;
        bit          lr;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          cn;
        bit          rdy;
        bit          bsy;
        bit          err;
        logic [15:0] wl;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        load_req = 1'b0;
        nrst = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic check_all(input string tag, input vec_t x);
        chk({tag, ".we"}, 32'(imem_we), 32'(x.we));
        chk({tag, ".addr"}, imem_addr, x.addr);
        chk({tag, ".wdata"}, imem_wdata, x.wd);
        chk({tag, ".core_nrst"}, 32'(core_nrst), 32'(x.cn));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(x.rdy));
        chk({tag, ".busy"}, 32'(busy), 32'(x.bsy));
        chk({tag, ".error"}, 32'(error), 32'(x.err));
        chk({tag, ".words"}, 32'(words_loaded), 32'(x.wl));
    endtask

    task automatic step(input vec_t x, input int idx);
        if (x.rst) do_reset();
        in_valid = x.v;
        in_data  = x.d;
        load_req = x.lr;
        check_all($sformatf("v%0d", idx), x);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit rst, input bit v, input logic [7:0] d, input bit lr, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd, input bit cn, input bit rdy,
                       input bit bsy, input bit err, input logic [15:0] wl);
        tbl.push_back(vec_t'{rst, v, d, lr, we, addr, wd, cn, rdy, bsy, err, wl});
    endtask

    logic [7:0] gap_bytes [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'hFF, 8'hFF};
    logic [7:0] abort_bytes [6] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] reload_bytes [6] = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};

    initial begin
        // Two-word load, then restart from RUN with a byte offered alongside load_req
        add(1,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h02,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h20,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h08,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h05,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h21,0, 1,0,32'h20080005,0,1,1,0,1);
        add(0,1,8'h29,0, 0,0,32'h20080005,0,1,1,0,1);
        add(0,1,8'hFF,0, 0,0,32'h20080005,0,1,1,0,1);
        add(0,1,8'hFF,0, 0,0,32'h20080005,0,1,1,0,1);
        add(0,0,8'h00,0, 1,4,32'h2129FFFF,0,0,0,0,2);
        add(0,1,8'hAB,0, 0,4,32'h2129FFFF,1,0,0,0,2);
        add(0,1,8'h00,1, 0,4,32'h2129FFFF,1,0,0,0,2);
        add(0,1,8'h00,0, 0,4,32'h2129FFFF,0,1,1,0,2);
        add(0,1,8'h01,0, 0,4,32'h2129FFFF,0,1,1,0,2);
        add(0,1,8'h12,0, 0,4,32'h2129FFFF,0,1,1,0,0);
        add(0,1,8'h34,0, 0,4,32'h2129FFFF,0,1,1,0,0);
        add(0,1,8'h56,0, 0,4,32'h2129FFFF,0,1,1,0,0);
        add(0,1,8'h78,0, 0,4,32'h2129FFFF,0,1,1,0,0);
        add(0,0,8'h00,0, 1,0,32'h12345678,0,0,0,0,1);
        add(0,0,8'h00,0, 0,0,32'h12345678,1,0,0,0,1);
        // Zero-length header goes straight to RUN
        add(1,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,0,8'h00,0, 0,0,0,0,0,0,0,0);
        add(0,0,8'h00,0, 0,0,0,1,0,0,0,0);
        // N = 257 rejected, recovery via load_req; load_req ignored while loading
        add(1,1,8'h01,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h01,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,0, 0,0,0,0,0,0,1,0);
        add(0,0,8'h00,1, 0,0,0,0,0,0,1,0);
        add(0,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h01,1, 0,0,0,0,1,1,0,0);
        add(0,1,8'h08,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,1, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,0,8'h00,0, 1,0,32'h08000000,0,0,0,0,1);
        add(0,0,8'h00,0, 0,0,32'h08000000,1,0,0,0,1);
        // N = DEPTH exactly is accepted
        add(1,1,8'h01,0, 0,0,0,0,1,1,0,0);
        add(0,1,8'h00,0, 0,0,0,0,1,1,0,0);
        add(0,0,8'h00,0, 0,0,0,0,1,1,0,0);

        foreach (tbl[i]) step(tbl[i], i);

        // Same two-word stream with three idle cycles after every byte
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = gap_bytes[i];
            chk($sformatf("gap%0d.in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            chk($sformatf("gap%0d.we", i), 32'(imem_we), 32'((i == 5) || (i == 9)));
            if (i == 5) begin
                chk("gap.addr0", imem_addr, 32'd0);
                chk("gap.data0", imem_wdata, 32'h20080005);
            end
            if (i == 9) begin
                chk("gap.addr1", imem_addr, 32'd4);
                chk("gap.data1", imem_wdata, 32'h2129FFFF);
                chk("gap.cn_k1", 32'(core_nrst), 32'd0);
            end
            for (int g = 0; g < 3; g++) begin
                in_data = 8'($urandom);
                @(posedge clk);
                #1;
                chk($sformatf("gap%0d_%0d.we", i, g), 32'(imem_we), 32'd0);
                if (i == 9 && g == 0) chk("gap.cn_k2", 32'(core_nrst), 32'd1);
            end
        end
        chk("gap.words", 32'(words_loaded), 32'd2);

        // Asynchronous abort after six bytes of a three-word load, then a clean reload
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = abort_bytes[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("abort.we_before", 32'(imem_we), 32'd1);
        chk("abort.data_before", imem_wdata, 32'h11223344);
        #2 nrst = 1'b0;
        #1 check_all("abort", vec_t'{0,0,8'h00,0, 0,0,0,0,1,1,0,0});
        @(posedge clk);
        #1 nrst = 1'b1;
        begin
            int pulses = 0;
            for (int i = 0; i < 8; i++) begin
                in_valid = (i < 6);
                in_data  = (i < 6) ? reload_bytes[i] : 8'h00;
                @(posedge clk);
                #1;
                if (imem_we) pulses++;
            end
            in_valid = 1'b0;
            chk("reload.pulses", 32'(pulses), 32'd1);
        end
        chk("reload.addr", imem_addr, 32'd0);
        chk("reload.data", imem_wdata, 32'hCAFEF00D);
        chk("reload.core_nrst", 32'(core_nrst), 32'd1);
        chk("reload.words", 32'(words_loaded), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
